// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator/detector pair:
// state encoding and default widths.
package seq_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_RPT_W = 3;
  localparam int STATE_W       = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_PARITY = 2'd2;
  localparam logic [STATE_W-1:0] ST_FIN    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY,
    S_FIN    = ST_FIN
  } seq_state_t;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in serial-out left-shift register; the MSB tap is the bit
// currently on the serial line.
module seq_piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB-first, repeated
// rpt+1 times. Define SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit per frame.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int RPT_W = DEFAULT_RPT_W,
  localparam int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [RPT_W-1:0] rpt,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] l_eff;
  logic [LEN_W-1:0] shamt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] load_data;
  logic             accept;
  logic             last_bit;
  logic             reload;
  logic             load;
  logic             shift_en;
  logic             tap;
  logic             done_next;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  logic             par;
`endif

  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);

  // Patterns are stored left-aligned so the first bit to send sits at the MSB tap.
  always_comb begin
    accept    = ready && start;
    l_eff     = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    shamt     = LEN_W'(WIDTH) - l_eff;
    aligned   = pattern << shamt;
    last_bit  = (state == S_SHIFT) && (bit_cnt == LEN_W'(1));
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    reload    = (state == S_PARITY) && (rpt_cnt != '0);
`else
    reload    = last_bit && (rpt_cnt != '0);
`endif
    load      = (accept && (l_eff != '0)) || reload;
    load_data = accept ? aligned : pat_reg;
    shift_en  = (state == S_SHIFT) && !last_bit;
  end

  // done is registered, so predict whether the next cycle carries the request's final bit.
  always_comb begin
    done_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          done_next = (l_eff == '0);
`else
          done_next = (l_eff == '0) || ((l_eff == LEN_W'(1)) && (rpt == '0));
`endif
        end
      end
      S_SHIFT: begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        done_next = last_bit && (rpt_cnt == '0);
`else
        if (!last_bit) begin
          done_next = (bit_cnt == LEN_W'(2)) && (rpt_cnt == '0);
        end else begin
          done_next = (rpt_cnt == RPT_W'(1)) && (len_reg == LEN_W'(1));
        end
`endif
      end
      default: done_next = 1'b0;
    endcase
  end

  seq_piso_shift #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift_en),
    .data  (load_data),
    .msb   (tap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pat_reg <= '0;
      len_reg <= '0;
      bit_cnt <= '0;
      rpt_cnt <= '0;
      done    <= 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done <= done_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_reg <= aligned;
            len_reg <= l_eff;
            bit_cnt <= l_eff;
            rpt_cnt <= rpt;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par     <= 1'b0;
`endif
            state   <= (l_eff == '0) ? S_FIN : S_SHIFT;
          end
        end
        S_SHIFT: begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
          par <= par ^ tap;
`endif
          if (!last_bit) begin
            bit_cnt <= bit_cnt - LEN_W'(1);
          end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            state <= S_PARITY;
`else
            if (rpt_cnt != '0) begin
              rpt_cnt <= rpt_cnt - RPT_W'(1);
              bit_cnt <= len_reg;
            end else begin
              state <= S_IDLE;
            end
`endif
          end
        end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        S_PARITY: begin
          par <= 1'b0;
          if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt - RPT_W'(1);
            bit_cnt <= len_reg;
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Serial line is forced low outside frame bits.
  always_comb begin
    out_valid = 1'b0;
    out       = 1'b0;
    case (state)
      S_SHIFT: begin
        out_valid = 1'b1;
        out       = tap;
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      S_PARITY: begin
        out_valid = 1'b1;
        out       = par;
      end
`endif
      default: begin
        out_valid = 1'b0;
        out       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: directed scenarios plus randomized requests
// checked against a bit-queue model built from pattern, length and repeat count.
module tb_seq_pattern_gen;

  localparam int WIDTH = 4;
  localparam int RPT_W = 3;
  localparam int LEN_W = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [RPT_W-1:0] rpt;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  int errors;
  int checks;
  bit exp_q[$];

  seq_pattern_gen #(.WIDTH(WIDTH), .RPT_W(RPT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .rpt       (rpt),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected serial stream: each frame is pattern[L-1..0], optionally followed by its parity.
  function automatic void build_expected(input logic [WIDTH-1:0] p, input int l_in, input int r_in);
    int l;
    exp_q.delete();
    l = (l_in > WIDTH) ? WIDTH : l_in;
    for (int f = 0; f <= r_in; f++) begin
      int ones = 0;
      for (int i = l - 1; i >= 0; i--) begin
        exp_q.push_back(p[i]);
        ones += int'(p[i]);
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      if (l > 0) exp_q.push_back((ones % 2) == 1);
`endif
    end
  endfunction

  task automatic pulse_start(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l, input logic [RPT_W-1:0] r);
    build_expected(p, int'(l), int'(r));
    pattern = p;
    len     = l;
    rpt     = r;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ready !== 1'b1 || out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: ready=%b out=%b valid=%b busy=%b done=%b, expected 1 0 0 0 0", ready, out, out_valid, busy, done);
    end
    #8 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b valid=%b busy=%b done=%b, expected 1 0 0 0", ready, out_valid, busy, done);
    end
  endtask

  task automatic test_basic(input string name, input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l, input logic [RPT_W-1:0] r);
    pulse_start(p, l, r);
    pattern = ~p;
    len     = 3'd1;
    rpt     = 3'd0;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== exp_q[k] || busy !== 1'b1 || ready !== 1'b0 || done !== (k == exp_q.size() - 1)) begin
        errors++;
        $display("[TB] FAIL %s bit %0d: out=%b valid=%b busy=%b done=%b, expected out=%b valid=1 busy=1 done=%b",
                 name, k, out, out_valid, busy, done, exp_q[k], (k == exp_q.size() - 1));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s end: ready=%b valid=%b out=%b done=%b busy=%b, expected 1 0 0 0 0", name, ready, out_valid, out, done, busy);
    end
  endtask

  task automatic test_zero_len();
    pulse_start(4'b1111, 3'd0, 3'd3);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || ready !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_len fin: valid=%b done=%b busy=%b ready=%b, expected 0 1 1 0", out_valid, done, busy, ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_len end: valid=%b done=%b ready=%b, expected 0 0 1", out_valid, done, ready);
    end
  endtask

  task automatic test_back_to_back();
    bit q2[$];
    build_expected(4'b0110, 4, 0);
    q2 = exp_q;
    build_expected(4'b1001, 4, 0);
    pattern = 4'b1001; len = 3'd4; rpt = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    pattern = 4'b0110;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== exp_q[k] || done !== (k == exp_q.size() - 1)) begin
        errors++;
        $display("[TB] FAIL b2b_first bit %0d: out=%b valid=%b done=%b, expected out=%b valid=1", k, out, out_valid, done, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_gap: ready=%b valid=%b done=%b, expected 1 0 0", ready, out_valid, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < q2.size(); k++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== q2[k] || done !== (k == q2.size() - 1)) begin
        errors++;
        $display("[TB] FAIL b2b_second bit %0d: out=%b valid=%b done=%b, expected out=%b valid=1", k, out, out_valid, done, q2[k]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: ready=%b valid=%b, expected 1 0", ready, out_valid);
    end
  endtask

  task automatic test_ignore_start();
    pulse_start(4'b1010, 3'd4, 3'd1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 1) begin
        pattern = 4'b0101; len = 3'd0; rpt = 3'd7; start = 1'b1;
      end
      if (k == 2) start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out !== exp_q[k] || done !== (k == exp_q.size() - 1)) begin
        errors++;
        $display("[TB] FAIL ignore_start bit %0d: out=%b valid=%b done=%b, expected out=%b valid=1", k, out, out_valid, done, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_start end: ready=%b valid=%b busy=%b, expected 1 0 0", ready, out_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    pulse_start(4'b1101, 3'd4, 3'd0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== exp_q[k]) begin
        errors++;
        $display("[TB] FAIL async_pre bit %0d: out=%b valid=%b, expected out=%b valid=1", k, out, out_valid, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_drop: out=%b valid=%b busy=%b done=%b ready=%b, expected 0 0 0 0 1", out, out_valid, busy, done, ready);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL async_hold cycle %0d: done=%b valid=%b, expected 0 0", c, done, out_valid);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    test_basic("after_reset", 4'b0111, 3'd4, 3'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int idle = $urandom_range(0, 2);
      for (int c = 0; c < idle; c++) begin
        @(posedge clk); #1;
      end
      pulse_start(WIDTH'($urandom), LEN_W'($urandom_range(0, 7)), RPT_W'($urandom_range(0, 7)));
      pattern = WIDTH'($urandom);
      len     = LEN_W'($urandom);
      rpt     = RPT_W'($urandom);
      if (exp_q.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL random req %0d zero_len: valid=%b done=%b, expected 0 1", n, out_valid, done);
        end
        @(posedge clk); #1;
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (out_valid !== 1'b1 || out !== exp_q[k] || busy !== 1'b1 || done !== (k == exp_q.size() - 1)) begin
            errors++;
            $display("[TB] FAIL random req %0d bit %0d: out=%b valid=%b busy=%b done=%b, expected out=%b valid=1 busy=1 done=%b",
                     n, k, out, out_valid, busy, done, exp_q[k], (k == exp_q.size() - 1));
          end
          @(posedge clk); #1;
        end
      end
      checks++;
      if (ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random req %0d end: ready=%b valid=%b done=%b, expected 1 0 0", n, ready, out_valid, done);
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    rpt     = '0;
    test_reset();
    test_basic("single_frame", 4'b1101, 3'd4, 3'd0);
    test_basic("repeat", 4'b1011, 3'd3, 3'd2);
    test_zero_len();
    test_basic("clamp_len7", 4'b1011, 3'd7, 3'd0);
    test_basic("single_bit_rpt", 4'b0001, 3'd1, 3'd2);
    test_basic("parity_case", 4'b1101, 3'd4, 3'd1);
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
